// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: ALU op codes, FSM state codes,
// step count and op-class decode helpers.
package muldiv_unit_pkg;

  localparam int unsigned MD_STEPS = 32;

  localparam logic [1:0] MD_STATE_IDLE = 2'd0;
  localparam logic [1:0] MD_STATE_CALC = 2'd1;
  localparam logic [1:0] MD_STATE_FIX  = 2'd2;
  localparam logic [1:0] MD_STATE_DONE = 2'd3;

  localparam logic [5:0] ALU_OP_ADD  = 6'h00;
  localparam logic [5:0] ALU_OP_SUB  = 6'h01;
  localparam logic [5:0] ALU_OP_AND  = 6'h02;
  localparam logic [5:0] ALU_OP_OR   = 6'h03;
  localparam logic [5:0] ALU_OP_XOR  = 6'h04;
  localparam logic [5:0] ALU_OP_NOR  = 6'h05;
  localparam logic [5:0] ALU_OP_SLT  = 6'h06;
  localparam logic [5:0] ALU_OP_SLTU = 6'h07;
  localparam logic [5:0] ALU_OP_SLL  = 6'h08;
  localparam logic [5:0] ALU_OP_SRL  = 6'h09;
  localparam logic [5:0] ALU_OP_SRA  = 6'h0A;
  localparam logic [5:0] ALU_OP_LUI  = 6'h0B;
  localparam logic [5:0] ALU_OP_MUL  = 6'h10;
  localparam logic [5:0] ALU_OP_MULU = 6'h11;
  localparam logic [5:0] ALU_OP_MUH  = 6'h12;
  localparam logic [5:0] ALU_OP_MUHU = 6'h13;
  localparam logic [5:0] ALU_OP_DIV  = 6'h14;
  localparam logic [5:0] ALU_OP_DIVU = 6'h15;
  localparam logic [5:0] ALU_OP_MOD  = 6'h16;
  localparam logic [5:0] ALU_OP_MODU = 6'h17;

  typedef enum logic [1:0] {
    StIdle = MD_STATE_IDLE,
    StCalc = MD_STATE_CALC,
    StFix  = MD_STATE_FIX,
    StDone = MD_STATE_DONE
  } md_state_e;

  function automatic logic op_is_mul(input logic [5:0] op);
    return op inside {ALU_OP_MUL, ALU_OP_MULU, ALU_OP_MUH, ALU_OP_MUHU};
  endfunction

  function automatic logic op_is_div(input logic [5:0] op);
    return op inside {ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_MOD, ALU_OP_MODU};
  endfunction

  function automatic logic op_is_signed(input logic [5:0] op);
    return op inside {ALU_OP_MUL, ALU_OP_MUH, ALU_OP_DIV, ALU_OP_MOD};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [5:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             illegal;

  modport master (
    output start, flush, alu_op, a, b,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, flush, alu_op, a, b,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 32-bit multiply/divide unit; multiply and divide share one 64-bit shift
// register (high half = accumulator/remainder, low half = multiplier/quotient).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave md
);

  md_state_e          state_q;
  logic [5:0]         count_q;
  logic [5:0]         op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   res_q;

  logic               op_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    op_signed = op_is_signed(md.alu_op);
    a_abs     = (op_signed && md.a[WIDTH-1]) ? -md.a : md.a;
    b_abs     = (op_signed && md.b[WIDTH-1]) ? -md.b : md.b;

    // Multiply: add multiplicand into the high half, then shift the whole register right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide: shift remainder left pulling in the next dividend bit (guard bit on top).
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem   = div_shift[WIDTH-1:0] - opb_q;

    if (op_is_div(op_q)) begin
      step_acc = {(div_ge ? div_rem : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_s = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Remainder follows the dividend's sign; with b==0 this restores the original a.
    rem_s = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (op_q)
      ALU_OP_MUL, ALU_OP_MULU: fix_val = prod[WIDTH-1:0];
      ALU_OP_MUH, ALU_OP_MUHU: fix_val = prod[2*WIDTH-1:WIDTH];
      ALU_OP_DIV, ALU_OP_DIVU: fix_val = (opb_q == '0) ? '1 : quo_s;
      ALU_OP_MOD, ALU_OP_MODU: fix_val = rem_s;
      default:                 fix_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      acc_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      md.busy    <= 1'b0;
      md.done    <= 1'b0;
      md.illegal <= 1'b0;
      md.result  <= '0;
    end else begin
      md.busy    <= (state_q != StIdle);
      md.done    <= 1'b0;
      md.illegal <= 1'b0;
      if (md.flush) begin
        state_q <= StIdle;
        count_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (md.start) begin
              op_q     <= md.alu_op;
              sign_a_q <= op_signed & md.a[WIDTH-1];
              sign_b_q <= op_signed & md.b[WIDTH-1];
              acc_q    <= {{WIDTH{1'b0}}, a_abs};
              opb_q    <= b_abs;
              count_q  <= '0;
              state_q  <= StCalc;
            end
          end
          StCalc: begin
            acc_q   <= step_acc;
            count_q <= count_q + 6'd1;
            if (count_q == 6'(MD_STEPS - 1)) begin
              state_q <= StFix;
            end
          end
          StFix: begin
            res_q   <= fix_val;
            state_q <= StDone;
          end
          StDone: begin
            md.result  <= res_q;
            md.done    <= 1'b1;
            md.illegal <= ~(op_is_mul(op_q) | op_is_div(op_q));
            state_q    <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
